// File: rtl/safe_softmax_tile_ctrl.sv
// Tile sequencer for the 16-row safe-softmax array.
// Accepts 16x16 score tiles over a valid/ready handshake, holds start to the
// array until it reports valid, feeds the per-row running max / exp-sum back
// into the array between tiles, and presents each normalised tile downstream.
//
// Ports
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_tile_vld/o_tile_rdy/i_tile_last/i_tile_data   upstream tile handshake
//   o_sm_start/o_sm_data/o_sm_x_max/o_sm_exp_sum    request to array
//   i_sm_vld/i_sm_data/i_sm_x_max/i_sm_exp_sum      result from array
//   o_vld/o_data/o_x_max/o_exp_sum/o_last/o_tile_idx downstream result
//   o_err               sticky array timeout flag
module safe_softmax_tile_ctrl #(
  parameter int unsigned D_W     = 8,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned IDX_W   = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_tile_vld,
  output logic                         o_tile_rdy,
  input  logic                         i_tile_last,
  input  logic [15:0][15:0][D_W-1:0]   i_tile_data,
  output logic                         o_sm_start,
  output logic [15:0][15:0][D_W-1:0]   o_sm_data,
  output logic [15:0][D_W-1:0]         o_sm_x_max,
  output logic [15:0][15:0]            o_sm_exp_sum,
  input  logic                         i_sm_vld,
  input  logic [15:0][15:0][D_W-1:0]   i_sm_data,
  input  logic [15:0][D_W-1:0]         i_sm_x_max,
  input  logic [15:0][15:0]            i_sm_exp_sum,
  output logic                         o_vld,
  output logic [15:0][15:0][D_W-1:0]   o_data,
  output logic [15:0][D_W-1:0]         o_x_max,
  output logic [15:0][15:0]            o_exp_sum,
  output logic                         o_last,
  output logic [IDX_W-1:0]             o_tile_idx,
  output logic                         o_err
);

  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);
  // Most negative signed score: the identity element for a running max.
  localparam logic [D_W-1:0] MAX_INIT = D_W'(1) << (D_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            accept_c;
  logic            capture_c;
  logic            timeout_c;
  logic            last_q;
  logic [WD_W-1:0] wd;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; a late array valid wins over the watchdog
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    capture_c = 1'b0;
    timeout_c = 1'b0;
    case (state)
      IDLE: begin
        if (i_tile_vld && o_tile_rdy) begin
          accept_c  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (i_sm_vld) begin
          capture_c = 1'b1;
          state_nxt = OUT;
        end else if (wd == WD_LIMIT) begin
          timeout_c = 1'b1;
          state_nxt = GAP;
        end
      end
      OUT:     state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake / control outputs, registered from the next state
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_tile_rdy <= 1'b0;
      o_sm_start <= 1'b0;
      o_vld      <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_tile_rdy <= (state_nxt == IDLE);
      o_sm_start <= (state_nxt == RUN);
      o_vld      <= capture_c;
      if (timeout_c) begin
        o_err <= 1'b1;
      end
    end
  end

  // Tile capture and saturating watchdog
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_sm_data <= '0;
      last_q    <= 1'b0;
      wd        <= '0;
    end else if (accept_c) begin
      o_sm_data <= i_tile_data;
      last_q    <= i_tile_last;
      wd        <= '0;
    end else if (state == RUN && wd != '1) begin
      wd <= wd + WD_W'(1);
    end
  end

  // Result capture; held until the next array valid
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_data    <= '0;
      o_x_max   <= '0;
      o_exp_sum <= '0;
      o_last    <= 1'b0;
    end else if (capture_c) begin
      o_data    <= i_sm_data;
      o_x_max   <= i_sm_x_max;
      o_exp_sum <= i_sm_exp_sum;
      o_last    <= last_q;
    end
  end

  // Running statistics and tile index; restart after a row block or abort
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_sm_x_max   <= {16{MAX_INIT}};
      o_sm_exp_sum <= '0;
      o_tile_idx   <= '0;
    end else if (capture_c) begin
      o_sm_x_max   <= i_sm_x_max;
      o_sm_exp_sum <= i_sm_exp_sum;
    end else if (timeout_c || (state == OUT && last_q)) begin
      o_sm_x_max   <= {16{MAX_INIT}};
      o_sm_exp_sum <= '0;
      o_tile_idx   <= '0;
    end else if (state == OUT) begin
      o_tile_idx   <= o_tile_idx + IDX_W'(1);
    end
  end

endmodule

// File: doc/safe_softmax_tile_ctrl.md
Name: safe_softmax_tile_ctrl

Overview:
Sequencer that drives the 16-row safe-softmax array, i.e. the initiator side of its start/valid protocol.
- Accepts 16x16 score tiles from upstream over a valid/ready handshake.
- Holds the per-row running max and running exp-sum between tiles and feeds them back to the array.
- Holds start asserted until the array reports valid, then presents the normalised tile, updated statistics and tile index to downstream.
- Re-initialises the statistics after the last tile of a row block.

Parameters:
D_W, 8, score/probability element width (signed scores in, unsigned probabilities out).
TIMEOUT, 64, maximum RUN cycles to wait for I_SM_VLD before abort.
IDX_W, 4, width of the tile index counter.

Ports:
I_CLK  in  1  clock.
I_RST_N  in  1  reset, synchronous, active-low.
I_TILE_VLD  in  1  upstream tile valid.
O_TILE_RDY  out  1  upstream ready.
I_TILE_LAST  in  1  tile is last of current row block; qualified by I_TILE_VLD.
I_TILE_DATA  in  D_W x[16][16]  score tile.
O_SM_START  out  1  start to array; held high while array computes.
O_SM_DATA  out  D_W x[16][16]  registered score tile to array.
O_SM_X_MAX  out  D_W x[16]  running row max to array.
O_SM_EXP_SUM  out  16 x[16]  running row exp-sum to array (1 sign, 10 int, 5 frac).
I_SM_VLD  in  1  array result valid.
I_SM_DATA  in  D_W x[16][16]  array probabilities.
I_SM_X_MAX  in  D_W x[16]  array updated max.
I_SM_EXP_SUM  in  16 x[16]  array updated exp-sum.
O_VLD  out  1  downstream result valid, single-cycle pulse.
O_DATA  out  D_W x[16][16]  captured probabilities.
O_X_MAX  out  D_W x[16]  captured max.
O_EXP_SUM  out  16 x[16]  captured exp-sum.
O_LAST  out  1  result belongs to last tile of row block.
O_TILE_IDX  out  IDX_W  index of tile within row block (0-based).
O_ERR  out  1  sticky timeout flag.

Behaviour:
- Reset: all state is synchronous, sampled on I_CLK when I_RST_N=0.
  - Outputs: O_TILE_RDY=0, O_SM_START=0, O_VLD=0, O_LAST=0, O_ERR=0, O_TILE_IDX=0, all data outputs 0.
  - Running state: O_SM_X_MAX[r]=8'h80 (most negative signed), O_SM_EXP_SUM[r]=0.
  - FSM -> IDLE.
- FSM states: IDLE, RUN, GAP, OUT.
- IDLE:
  - O_TILE_RDY=1.
  - On I_TILE_VLD&O_TILE_RDY: register I_TILE_DATA into O_SM_DATA, latch I_TILE_LAST into an internal last flag, clear the watchdog, go to RUN.
  - O_TILE_RDY drops in the cycle after the accept.
- RUN:
  - O_SM_START=1 constantly; O_SM_DATA/X_MAX/EXP_SUM stable.
  - Watchdog increments each cycle.
  - On I_SM_VLD=1: capture I_SM_DATA/X_MAX/EXP_SUM into O_DATA/O_X_MAX/O_EXP_SUM; copy I_SM_X_MAX/I_SM_EXP_SUM into O_SM_X_MAX/O_SM_EXP_SUM (feedback); go to OUT.
  - If the watchdog reaches TIMEOUT-1 without I_SM_VLD: set O_ERR=1, reset running state to init, reset O_TILE_IDX=0, go to GAP without asserting O_VLD.
- OUT:
  - O_VLD=1 for exactly one cycle; O_LAST = latched last flag.
  - O_SM_START=0.
  - In the same cycle, update the index and running state:
    - If last: O_TILE_IDX<=0 and running state <= init values.
    - Else: O_TILE_IDX<=O_TILE_IDX+1, wrapping modulo 2^IDX_W.
  - Go to GAP.
- GAP:
  - One cycle with O_SM_START=0 and O_TILE_RDY=0, so the array restarts cleanly; then go to IDLE.
- Latency: accept cycle -> O_SM_START high next cycle; I_SM_VLD sampled at edge k -> O_VLD high during the cycle after edge k.
- Minimum tile period: 4 cycles with 1-cycle array latency.
- Captured outputs hold their values until the next capture. No downstream backpressure.
- I_SM_VLD outside RUN is ignored.
- I_TILE_VLD outside IDLE is not accepted; upstream must hold it.
- O_ERR clears only on reset.
- Reset mid-RUN: O_SM_START falls on the reset edge and all state returns to reset values.
- Arithmetic: none in this block beyond the watchdog (ceil(log2 TIMEOUT) bits, saturating) and the index counter.

Test Plan:
- Single last tile, all scores 8'h10, array model latency 3 -> O_SM_X_MAX=8'h80 and O_SM_EXP_SUM=0 during RUN; START high exactly 3 cycles; one O_VLD with O_LAST=1, O_TILE_IDX=0; running state back to 8'h80/0 afterwards.
- Three tiles, last on the third, model returns max 8'h20/8'h30/8'h30 and sum 16'h0100/0180/0200 -> tile 2 sees O_SM_X_MAX=8'h20 and O_SM_EXP_SUM=16'h0100; tile 3 sees 8'h30/16'h0180; O_TILE_IDX=0,1,2; O_LAST only on the third.
- Upstream holds I_TILE_VLD continuously -> accepts spaced ≥4 cycles; exactly one accept per O_VLD; O_TILE_RDY=0 in RUN/OUT/GAP.
- Model never asserts valid, TIMEOUT=8 -> START drops after 8 RUN cycles; O_ERR=1 sticky; no O_VLD; next tile starts from 8'h80/0 with IDX 0.
- Reset asserted mid-RUN on tile 2 -> next edge: START=0, IDX=0, O_SM_X_MAX=8'h80, O_ERR=0; the next tile runs normally.
- IDX_W=2 with 5 non-last tiles -> O_TILE_IDX sequence 0,1,2,3,0; spurious I_SM_VLD pulse in IDLE produces no O_VLD and no state change.
